// File: rtl/mem_pingpong_sequencer_if.sv
// Bundle of the three streams that meet at the ping-pong sequencer:
//   write stream in  : wr_valid, wr_data, wr_ready
//   read stream out  : rd_valid, rd_data, rd_last, rd_ready
//   memory command   : mem_req, memoryena, mem_addr, mem_din, mem_dout
//   status           : blk_full
// The master modport is the sequencer; the slave modport is everything around it
// (deserializer, serializer, BRAM/decoder).
interface mem_pingpong_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;

  logic              mem_req;
  logic [1:0]        memoryena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic [1:0]        blk_full;

  modport master (
    input  wr_valid, wr_data, rd_ready, mem_dout,
    output wr_ready, rd_valid, rd_data, rd_last,
    output mem_req, memoryena, mem_addr, mem_din, blk_full
  );

  modport slave (
    output wr_valid, wr_data, rd_ready, mem_dout,
    input  wr_ready, rd_valid, rd_data, rd_last,
    input  mem_req, memoryena, mem_addr, mem_din, blk_full
  );
endinterface

// File: rtl/mem_pingpong_sequencer.sv
// Ping-pong BRAM sequencer. Streams incoming words into two BRAM blocks alternately
// and drains each filled block, in fill order, to a downstream consumer. At most one
// memory command per cycle is issued on the shared command bus.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; discards all buffered contents
//   bus    - master side of mem_pingpong_sequencer_if:
//            write stream in (wr_valid/wr_data/wr_ready),
//            read stream out (rd_valid/rd_data/rd_last/rd_ready),
//            memory command (mem_req/memoryena/mem_addr/mem_din, mem_dout returns
//            one cycle after a read command), blk_full status per block.
//
// memoryena = {block_sel, write}: 00 rd blk1, 01 wr blk1, 10 rd blk2, 11 wr blk2.
module mem_pingpong_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_pingpong_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic              wr_blk_q;
  logic              rd_blk_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic              rd_inflight_q;
  logic              last_pend_q;   // rd_last flag for the word currently in flight
  logic              prio_q;        // winner of the next contest: 0 = write, 1 = read
  logic [1:0]        blk_full_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_last_q;

  logic wr_req;
  logic rd_req;
  logic contest;
  logic wr_gnt;
  logic rd_gnt;

  // Requests are gated by rst_n so nothing is issued while reset is held, even though
  // a freshly reset write side would otherwise look eligible.
  always_comb begin
    wr_req  = rst_n & bus.wr_valid & ~blk_full_q[wr_blk_q];
    // A read may only be issued if its return has somewhere to land next cycle.
    rd_req  = rst_n & blk_full_q[rd_blk_q] & ~rd_inflight_q & (~rd_valid_q | bus.rd_ready);
    contest = wr_req & rd_req;
    wr_gnt  = wr_req & (~rd_req | ~prio_q);
    rd_gnt  = rd_req & (~wr_req | prio_q);
  end

  assign bus.wr_ready  = wr_gnt;
  assign bus.mem_req   = wr_gnt | rd_gnt;
  assign bus.memoryena = wr_gnt ? {wr_blk_q, 1'b1} :
                         rd_gnt ? {rd_blk_q, 1'b0} : 2'b00;
  assign bus.mem_addr  = wr_gnt ? wr_cnt_q : rd_gnt ? rd_cnt_q : '0;
  assign bus.mem_din   = wr_gnt ? bus.wr_data : '0;

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.blk_full  = blk_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_blk_q      <= 1'b0;
      rd_blk_q      <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      rd_inflight_q <= 1'b0;
      last_pend_q   <= 1'b0;
      prio_q        <= 1'b0;
      blk_full_q    <= 2'b00;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_last_q     <= 1'b0;
    end else begin
      if (contest) begin
        prio_q <= ~prio_q;
      end

      if (wr_gnt) begin
        if (wr_cnt_q == LastAddr) begin
          blk_full_q[wr_blk_q] <= 1'b1;
          wr_blk_q             <= ~wr_blk_q;
          wr_cnt_q             <= '0;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end

      // A grant requires no read in flight, so in-flight lasts exactly one cycle.
      rd_inflight_q <= rd_gnt;
      if (rd_gnt) begin
        last_pend_q <= (rd_cnt_q == LastAddr);
        if (rd_cnt_q == LastAddr) begin
          // Free the block on the final read command; its data is already requested.
          blk_full_q[rd_blk_q] <= 1'b0;
          rd_blk_q             <= ~rd_blk_q;
          rd_cnt_q             <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end

      // Output register: a return always finds it empty or being emptied this edge.
      if (rd_inflight_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.mem_dout;
        rd_last_q  <= last_pend_q;
      end else if (rd_valid_q && bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_pingpong_sequencer.md
Name: mem_pingpong_sequencer

Overview:
Initiator side of the 2-bit memory command code (memoryena). Streams incoming words into two BRAM blocks in ping-pong fashion and drains each filled block to a downstream consumer. Issues at most one memory command per cycle on a single shared command/address/data bus. Sits between the deserializer (write stream in) and the serializer (read stream out), in front of the memory-command decoder.

Parameters:
DATA_W, 8, width of data words
ADDR_W, 4, BRAM address width per block
DEPTH, 16, words per block before swap; legal range 2..2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  input word available
wr_data  in  DATA_W  input word
wr_ready  out  1  input word accepted this cycle when wr_valid&wr_ready
rd_valid  out  1  output word held
rd_data  out  DATA_W  output word
rd_last  out  1  rd_data is the last word (address DEPTH-1) of its block
rd_ready  in  1  consumer accepts output word
mem_req  out  1  memoryena/mem_addr/mem_din valid this cycle
memoryena  out  2  {block_sel, write}: 00 rd blk1, 01 wr blk1, 10 rd blk2, 11 wr blk2
mem_addr  out  ADDR_W  word address within the selected block
mem_din  out  DATA_W  write data (equals wr_data on write commands)
mem_dout  in  DATA_W  BRAM read data, valid 1 cycle after a read command
blk_full  out  2  bit0 = block1 full/undrained, bit1 = block2 full/undrained

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Internal state: wr_blk=0, rd_blk=0, wr_cnt=0, rd_cnt=0, rd_inflight=0, prio=write.
- When mem_req=0, memoryena=00 and mem_addr=0. The downstream decoder is gated by mem_req.
- Write eligible: !blk_full[wr_blk].
- Read eligible: blk_full[rd_blk] & !rd_inflight & (!rd_valid | rd_ready).
- Arbitration, one command per cycle:
  - Only one eligible and requesting (write requires wr_valid): it is granted.
  - Both: round-robin. prio flips after every contested grant; first contest after reset goes to write.
- wr_ready is combinational: write eligible & write granted this cycle.
- Write grant:
  - mem_req=1, memoryena={wr_blk,1}, mem_addr=wr_cnt, mem_din=wr_data.
  - wr_cnt++.
  - On wr_cnt==DEPTH-1: set blk_full[wr_blk], toggle wr_blk, wr_cnt<=0.
- Read grant:
  - mem_req=1, memoryena={rd_blk,0}, mem_addr=rd_cnt.
  - rd_inflight<=1; the last-flag for this word is recorded as (rd_cnt==DEPTH-1).
  - On rd_cnt==DEPTH-1: clear blk_full[rd_blk] in the same edge, toggle rd_blk, rd_cnt<=0.
  - The cleared block is write-eligible the next cycle.
- Read return: the cycle after a read grant, rd_data<=mem_dout, rd_last<=recorded flag, rd_valid<=1, rd_inflight<=0.
- Output register: rd_valid/rd_data/rd_last hold stable until rd_valid&rd_ready. Then rd_valid clears unless a return lands in the same edge, in which case the new word loads.
- Ordering: blocks drain in fill order, addresses ascending 0..DEPTH-1. Data out equals data in, order preserved, no loss, no duplication.
- Read throughput: at most 1 word per 2 cycles (no second read while one is in flight).
- Both blocks full: wr_ready=0 until the first read-out completes a block.
- Simultaneous final write into one block and final read of the other in the same cycle: impossible (one grant per cycle). No special case.
- Reset mid-operation: all contents are logically discarded (blk_full=00, counters 0, rd_valid=0) immediately and asynchronously.
- Unknown memoryena is never driven. mem_req=0 whenever no grant.

Test Plan:
- Reset with wr_valid=1 -> during rst_n=0: wr_ready=0, mem_req=0, memoryena=00, blk_full=00, rd_valid=0. After release, first write: memoryena=01, mem_addr=0.
- Stream 16 words 0x00..0x0F, rd_ready=0 -> writes to blk1 addr 0..15 (memoryena=01), then blk_full=01. Next write goes to blk2 addr 0 (memoryena=11).
- Continuous wr_valid and rd_ready after blk1 full -> memoryena alternates write/read round-robin. Reads 10 addr 0..15 wait, reads are blk1 first (00). Output sequence 0x00..0x0F with rd_last=1 only on 0x0F.
- 32 words in, rd_ready=0 -> blk_full=11, wr_ready=0, mem_req=0. Then rd_ready=1 -> one read every 2 cycles. After 16th read grant, blk_full=10 and wr_ready returns next cycle.
- rd_ready toggling 1/0 every cycle over 48 words -> rd_data held stable while rd_ready=0. Output equals input sequence exactly, 3 rd_last pulses.
- Assert rst_n=0 mid-block (wr_cnt=7, rd_valid=1) -> outputs 0 immediately. Post-reset, the next write targets memoryena=01 addr 0.
